mem_access_unit: RTL and testbench

Load/store front end for the pipeline's MEM stage. It sits directly upstream of the data memory / peripheral block and drives that block's word-only rd/wr/addr/wdata/rdata interface. It adds byte and halfword access, sign or zero extension of loads, and alignment checking. Sub-word stores to RAM are done as a two-cycle read-modify-write, and the unit stalls the pipeline for the extra cycle.

---
 rtl/mem_access_unit.sv | 155 +++++++++++++++
 tb/tb_mem_access_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store front end for a word-only data memory.
// Adds byte/halfword loads with sign or zero extension, alignment checking,
// and sub-word stores to RAM as a two-cycle read-modify-write.
//
// Handshake: there is no valid/ready pair on the request side. A request is
// presented while req_load/req_store is high and is consumed at the next edge
// unless stall is high, in which case the pipeline holds it for another cycle.
// mem_wait from the memory side forces stall and suppresses every access.
module mem_access_unit #(
   parameter logic [31:0] RAM_LIMIT = 32'h0000_0400
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_load,
   input  logic        req_store,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        ld_valid,
   output logic [31:0] ld_data,
   output logic        exc_align,
   output logic [31:0] exc_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_wait
);

   typedef enum logic {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] merge_q;
   logic [31:0] merge_next;
   logic [31:0] addr_q;
   logic [31:0] addr_next;

   logic        has_req;
   logic        illegal;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;
   logic [31:0] merged;

   // Decode request legality; sub-word stores outside RAM cannot do RMW.
   always_comb begin
      has_req = req_load | req_store;
      illegal = 1'b0;
      if (has_req) begin
         if (req_size == 2'b11)                              illegal = 1'b1;
         if (req_size == 2'b01 && req_addr[0])               illegal = 1'b1;
         if (req_size == 2'b10 && req_addr[1:0] != 2'b00)    illegal = 1'b1;
         if (req_load && req_store)                          illegal = 1'b1;
         if (req_store && !req_size[1] && req_addr >= RAM_LIMIT) illegal = 1'b1;
      end
   end

   // Select the addressed little-endian lane and extend it for loads.
   always_comb begin
      byte_sel = mem_rdata[{req_addr[1:0], 3'b000} +: 8];
      half_sel = req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (req_size)
         2'b00:   load_ext = req_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         2'b01:   load_ext = req_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: load_ext = mem_rdata;
      endcase
   end

   // Build the RMW word: current memory word with the addressed lane replaced.
   always_comb begin
      merged = mem_rdata;
      if (req_size == 2'b00) begin
         merged[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
      end else begin
         merged[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
      end
   end

   // Next-state and output decode; reset and mem_wait force quiet outputs.
   always_comb begin
      state_next = state;
      merge_next = merge_q;
      addr_next  = addr_q;
      stall      = 1'b0;
      ld_valid   = 1'b0;
      ld_data    = 32'h0;
      exc_align  = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = {req_addr[31:2], 2'b00};
      mem_wdata  = 32'h0;
      if (reset) begin
         // Outputs stay idle so a pending RMW write is dropped.
      end else if (mem_wait) begin
         stall = 1'b1;
         if (state == RMW_WR) begin
            mem_addr = {addr_q[31:2], 2'b00};
         end
      end else begin
         case (state)
            IDLE: begin
               if (illegal) begin
                  exc_align = 1'b1;
               end else if (req_load) begin
                  mem_rd   = 1'b1;
                  ld_valid = 1'b1;
                  ld_data  = load_ext;
               end else if (req_store) begin
                  if (req_size == 2'b10) begin
                     mem_wr    = 1'b1;
                     mem_wdata = req_wdata;
                  end else begin
                     mem_rd     = 1'b1;
                     stall      = 1'b1;
                     merge_next = merged;
                     addr_next  = req_addr;
                     state_next = RMW_WR;
                  end
               end
            end
            default: begin
               mem_wr     = 1'b1;
               mem_addr   = {addr_q[31:2], 2'b00};
               mem_wdata  = merge_q;
               state_next = IDLE;
            end
         endcase
      end
   end

   // State, RMW holding registers and the faulting-address capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         merge_q  <= 32'h0;
         addr_q   <= 32'h0;
         exc_addr <= 32'h0;
      end else begin
         state   <= state_next;
         merge_q <= merge_next;
         addr_q  <= addr_next;
         if (exc_align) begin
            exc_addr <= req_addr;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven single-cycle vectors plus hand-written
// multi-cycle sequences, with a write scoreboard on the memory bus.
module tb_mem_access_unit;

   localparam logic [31:0] RAM_LIMIT = 32'h0000_0400;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset;
   always #5 clk = ~clk;

   logic        req_load, req_store, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        stall, ld_valid, exc_align, mem_rd, mem_wr, mem_wait;
   logic [31:0] ld_data, exc_addr, mem_addr, mem_wdata, mem_rdata;

   mem_access_unit #(.RAM_LIMIT(RAM_LIMIT)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_load     (req_load),
      .req_store    (req_store),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .stall        (stall),
      .ld_valid     (ld_valid),
      .ld_data      (ld_data),
      .exc_align    (exc_align),
      .exc_addr     (exc_addr),
      .mem_rd       (mem_rd),
      .mem_wr       (mem_wr),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_wait     (mem_wait)
   );

   // ---------------- memory model ----------------
   logic [31:0] ram [0:255];
   logic        pre_we = 1'b0;
   logic [7:0]  pre_idx = 8'h0;
   logic [31:0] pre_data = 32'h0;

   assign mem_rdata = (mem_addr < RAM_LIMIT) ? ram[mem_addr[9:2]] : 32'hDEAD_BEEF;

   always @(posedge clk) begin
      if (pre_we) ram[pre_idx] <= pre_data;
      else if (mem_wr && mem_addr < RAM_LIMIT) ram[mem_addr[9:2]] <= mem_wdata;
   end

   // ---------------- scoreboard ----------------
   logic [63:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] exp_exc_addr = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d);
      req_load = ld; req_store = st; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = d;
   endtask

   task automatic drive_idle();
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h1234_567B, 32'h0);
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // Any write seen on the bus must match the head of the expected queue.
   task automatic advance();
      logic [63:0] w;
      if (mem_wr === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
         end else begin
            w = exp_q.pop_front();
            if ({mem_addr, mem_wdata} !== w) begin
               n_fail++;
               $display("FAIL write: got addr %h data %h expected addr %h data %h",
                        mem_addr, mem_wdata, w[63:32], w[31:0]);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [7:0] idx, input logic [31:0] d);
      drive_idle();
      pre_we = 1'b1; pre_idx = idx; pre_data = d;
      settle();
      advance();
      pre_we = 1'b0;
   endtask

   task automatic chk_ctl(input string tag, input logic e_stall, input logic e_rd, input logic e_wr);
      chk1({tag, "_stall"}, stall, e_stall);
      chk1({tag, "_rd"}, mem_rd, e_rd);
      chk1({tag, "_wr"}, mem_wr, e_wr);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        ld;
      logic        st;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        e_stall;
      logic        e_ldv;
      logic        e_exc;
      logic        e_rd;
      logic        e_wr;
      logic [31:0] e_ld;
   } vec_t;

   vec_t vecs[$];

   initial begin
      vec_t v;
      // ld st sz uns addr wdata | stall ldv exc rd wr ld_data
      vecs.push_back(vec_t'{1, 0, 2'd0, 1, 32'h13, 32'h0, 0, 1, 0, 1, 0, 32'h0000_0080});
      vecs.push_back(vec_t'{1, 0, 2'd0, 0, 32'h13, 32'h0, 0, 1, 0, 1, 0, 32'hFFFF_FF80});
      vecs.push_back(vec_t'{1, 0, 2'd0, 0, 32'h10, 32'h0, 0, 1, 0, 1, 0, 32'h0000_0001});
      vecs.push_back(vec_t'{1, 0, 2'd0, 1, 32'h12, 32'h0, 0, 1, 0, 1, 0, 32'h0000_00FF});
      vecs.push_back(vec_t'{1, 0, 2'd1, 0, 32'h12, 32'h0, 0, 1, 0, 1, 0, 32'hFFFF_80FF});
      vecs.push_back(vec_t'{1, 0, 2'd1, 1, 32'h12, 32'h0, 0, 1, 0, 1, 0, 32'h0000_80FF});
      vecs.push_back(vec_t'{1, 0, 2'd1, 0, 32'h10, 32'h0, 0, 1, 0, 1, 0, 32'h0000_7F01});
      vecs.push_back(vec_t'{1, 0, 2'd2, 0, 32'h10, 32'h0, 0, 1, 0, 1, 0, 32'h80FF_7F01});
      vecs.push_back(vec_t'{1, 0, 2'd2, 0, 32'h06, 32'h0, 0, 0, 1, 0, 0, 32'h0});
      vecs.push_back(vec_t'{1, 0, 2'd1, 1, 32'h11, 32'h0, 0, 0, 1, 0, 0, 32'h0});
      vecs.push_back(vec_t'{1, 0, 2'd3, 0, 32'h10, 32'h0, 0, 0, 1, 0, 0, 32'h0});
      vecs.push_back(vec_t'{1, 1, 2'd2, 0, 32'h10, 32'h0, 0, 0, 1, 0, 0, 32'h0});
      vecs.push_back(vec_t'{0, 1, 2'd0, 0, 32'h4000_0010, 32'hAA, 0, 0, 1, 0, 0, 32'h0});
      vecs.push_back(vec_t'{0, 1, 2'd1, 0, 32'h0000_0400, 32'hBBBB, 0, 0, 1, 0, 0, 32'h0});
      vecs.push_back(vec_t'{0, 1, 2'd2, 0, 32'h4000_0010, 32'h1234_5678, 0, 0, 0, 0, 1, 32'h0});
      vecs.push_back(vec_t'{0, 1, 2'd2, 0, 32'h0000_03FC, 32'hCAFE_F00D, 0, 0, 0, 0, 1, 32'h0});
      vecs.push_back(vec_t'{0, 0, 2'd0, 0, 32'h77, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 32'h0});
      vecs.push_back(vec_t'{0, 1, 2'd2, 0, 32'h22, 32'h1, 0, 0, 1, 0, 0, 32'h0});
      vecs.push_back(vec_t'{1, 0, 2'd0, 0, 32'h3FF, 32'h0, 0, 1, 0, 1, 0, 32'hFFFF_FFCA});

      // ---- reset state ----
      mem_wait = 1'b0;
      reset = 1'b1;
      drive_idle();
      @(posedge clk);
      #1;
      settle();
      chk_ctl("reset", 1'b0, 1'b0, 1'b0);
      chk1("reset_ldv", ld_valid, 1'b0);
      chk1("reset_exc", exc_align, 1'b0);
      chk("reset_ld_data", ld_data, 32'h0);
      chk("reset_mem_addr", mem_addr, 32'h1234_5678);
      chk("reset_exc_addr", exc_addr, 32'h0);
      advance();
      reset = 1'b0;

      preload(8'd4, 32'h80FF_7F01);

      // ---- single-cycle vectors ----
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         drive(v.ld, v.st, v.size, v.uns, v.addr, v.wdata);
         if (v.e_wr) expect_write({v.addr[31:2], 2'b00}, v.wdata);
         settle();
         chk_ctl($sformatf("vec%0d", i), v.e_stall, v.e_rd, v.e_wr);
         chk1($sformatf("vec%0d_ldv", i), ld_valid, v.e_ldv);
         chk1($sformatf("vec%0d_exc", i), exc_align, v.e_exc);
         chk($sformatf("vec%0d_ld_data", i), ld_data, v.e_ld);
         chk($sformatf("vec%0d_mem_addr", i), mem_addr, {v.addr[31:2], 2'b00});
         chk($sformatf("vec%0d_exc_addr", i), exc_addr, exp_exc_addr);
         if (!v.ld && !v.st) chk($sformatf("vec%0d_idle_wdata", i), mem_wdata, 32'h0);
         advance();
         if (v.e_exc) exp_exc_addr = v.addr;
      end
      drive_idle();
      settle();
      chk("exc_addr_after_table", exc_addr, exp_exc_addr);
      advance();

      // ---- halfword RMW @0x12 ----
      preload(8'd4, 32'h1122_3344);
      drive(1'b0, 1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_ABCD);
      settle();
      chk_ctl("hs_c0", 1'b1, 1'b1, 1'b0);
      chk1("hs_c0_ldv", ld_valid, 1'b0);
      expect_write(32'h10, 32'hABCD_3344);
      advance();
      settle();
      chk_ctl("hs_c1", 1'b0, 1'b0, 1'b1);
      chk("hs_c1_wdata", mem_wdata, 32'hABCD_3344);
      advance();
      drive_idle();
      settle();
      chk("hs_ram", ram[4], 32'hABCD_3344);
      chk_ctl("hs_after", 1'b0, 1'b0, 1'b0);
      advance();

      // ---- byte RMW @0x21 with mem_wait ----
      preload(8'd8, 32'hA5B6_C7D8);
      drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00EE);
      mem_wait = 1'b1;
      for (int c = 0; c < 3; c++) begin
         settle();
         chk_ctl($sformatf("wait%0d", c), 1'b1, 1'b0, 1'b0);
         advance();
      end
      mem_wait = 1'b0;
      settle();
      chk_ctl("wait_rd", 1'b1, 1'b1, 1'b0);
      chk("wait_rd_addr", mem_addr, 32'h20);
      expect_write(32'h20, 32'hA5B6_EED8);
      advance();
      // In RMW_WR the request inputs are ignored, including the address.
      drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h3C, 32'h0);
      mem_wait = 1'b1;
      settle();
      chk_ctl("wait_wr_hold", 1'b1, 1'b0, 1'b0);
      advance();
      mem_wait = 1'b0;
      settle();
      chk_ctl("wait_wr", 1'b0, 1'b0, 1'b1);
      chk("wait_wr_addr", mem_addr, 32'h20);
      chk1("wait_wr_ldv", ld_valid, 1'b0);
      advance();

      // ---- back-to-back byte store to the same word ----
      drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h20, 32'h0000_0011);
      settle();
      chk_ctl("b2b_c0", 1'b1, 1'b1, 1'b0);
      expect_write(32'h20, 32'hA5B6_EE11);
      advance();
      settle();
      chk_ctl("b2b_c1", 1'b0, 1'b0, 1'b1);
      advance();
      drive_idle();
      settle();
      chk("b2b_ram", ram[8], 32'hA5B6_EE11);
      advance();

      // ---- reset during RMW_WR ----
      preload(8'd12, 32'h5566_7788);
      drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h30, 32'h0000_0099);
      settle();
      chk_ctl("rst_c0", 1'b1, 1'b1, 1'b0);
      advance();
      reset = 1'b1;
      settle();
      chk_ctl("rst_c1", 1'b0, 1'b0, 1'b0);
      advance();
      reset = 1'b0;
      exp_exc_addr = 32'h0;
      drive_idle();
      settle();
      chk_ctl("rst_after", 1'b0, 1'b0, 1'b0);
      chk("rst_exc_addr", exc_addr, exp_exc_addr);
      chk("rst_ram", ram[12], 32'h5566_7788);
      advance();
      drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
      settle();
      chk_ctl("rst_load", 1'b0, 1'b1, 1'b0);
      chk1("rst_load_ldv", ld_valid, 1'b1);
      chk("rst_load_data", ld_data, 32'h5566_7788);
      advance();
      drive_idle();
      settle();
      advance();

      // ---- final report ----
      chk("pending_writes", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
